// File: rtl/core_redirect_ctrl_pkg.sv
// structures: shared types for the fetch redirect controller.
//   redirect_src_t : source of the PC presented to fetch, ordered by priority
//                    (a larger encoding wins over a smaller one).
//   redir_state_t  : controller FSM states.
//   src_flushes_id : redirect sources that also squash the ID/EX register.
package structures;

  typedef enum logic [2:0] {
    SRC_SEQ     = 3'd0,
    SRC_BOOT    = 3'd1,
    SRC_JUMP    = 3'd2,
    SRC_BRANCH  = 3'd3,
    SRC_ERET    = 3'd4,
    SRC_HANDLER = 3'd5
  } redirect_src_t;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } redir_state_t;

  // A jump resolves in ID, so the instruction in ID/EX is still on-path;
  // every later-resolved redirect must also kill ID/EX.
  function automatic logic src_flushes_id(input redirect_src_t s);
    return (s == SRC_BRANCH) || (s == SRC_ERET) || (s == SRC_HANDLER);
  endfunction

endpackage

// File: rtl/core_redirect_ctrl_prio.sv
// redirect_prio: purely combinational fixed-priority redirect selector.
//   handler > eret > ex branch > id jump > sequential (pc4).
// Ports:
//   take_handler/handler_addr, eret/epc, ex_branch_taken/ex_branch_target,
//   id_jump/id_jump_target : requests and their targets
//   pc4                    : fallback sequential PC
//   sel_target/sel_src     : winning target and its source
//   sel_valid              : a non-sequential request won
module redirect_prio
  import structures::*;
(
  input  logic          take_handler,
  input  logic [63:0]   handler_addr,
  input  logic          eret,
  input  logic [63:0]   epc,
  input  logic          ex_branch_taken,
  input  logic [63:0]   ex_branch_target,
  input  logic          id_jump,
  input  logic [63:0]   id_jump_target,
  input  logic [63:0]   pc4,
  output logic [63:0]   sel_target,
  output redirect_src_t sel_src,
  output logic          sel_valid
);

  always_comb begin
    sel_target = pc4;
    sel_src    = SRC_SEQ;
    sel_valid  = 1'b0;
    if (take_handler) begin
      sel_target = handler_addr;
      sel_src    = SRC_HANDLER;
      sel_valid  = 1'b1;
    end else if (eret) begin
      sel_target = epc;
      sel_src    = SRC_ERET;
      sel_valid  = 1'b1;
    end else if (ex_branch_taken) begin
      sel_target = ex_branch_target;
      sel_src    = SRC_BRANCH;
      sel_valid  = 1'b1;
    end else if (id_jump) begin
      sel_target = id_jump_target;
      sel_src    = SRC_JUMP;
      sel_valid  = 1'b1;
    end
  end

endmodule

// File: rtl/core_redirect_ctrl.sv
// core_redirect_ctrl: chooses the PC presented to fetch and the pipeline
// squash signals. A redirect that fetch cannot take this cycle is parked in
// pending registers (HOLD) until fetch_ready; a strictly higher-priority
// request arriving in HOLD replaces the parked one.
// Optional macro CORE_REDIRECT_PERF_EN adds redirect_count / hold_cycles.
// Ports:
//   clk, rst_n (async, active low)
//   take_handler/handler_addr, eret/epc, ex_branch_taken/ex_branch_target,
//   id_jump/id_jump_target, pc4, fetch_ready : inputs
//   next_pc, flush_if, flush_id, redirect_src, busy : outputs
//   redirect_count, hold_cycles : perf outputs (CORE_REDIRECT_PERF_EN only)
module core_redirect_ctrl
  import structures::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          take_handler,
  input  logic [63:0]   handler_addr,
  input  logic          eret,
  input  logic [63:0]   epc,
  input  logic          ex_branch_taken,
  input  logic [63:0]   ex_branch_target,
  input  logic          id_jump,
  input  logic [63:0]   id_jump_target,
  input  logic [63:0]   pc4,
  input  logic          fetch_ready,
  output logic [63:0]   next_pc,
  output logic          flush_if,
  output logic          flush_id,
  output redirect_src_t redirect_src,
`ifdef CORE_REDIRECT_PERF_EN
  output logic [31:0]   redirect_count,
  output logic [31:0]   hold_cycles,
`endif
  output logic          busy
);

  redir_state_t  state, state_nxt;
  logic [63:0]   pend_tgt, pend_tgt_nxt;
  redirect_src_t pend_src, pend_src_nxt;

  logic [63:0]   sel_target;
  redirect_src_t sel_src;
  logic          sel_valid;

  redirect_prio u_prio (
    .take_handler     (take_handler),
    .handler_addr     (handler_addr),
    .eret             (eret),
    .epc              (epc),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .id_jump          (id_jump),
    .id_jump_target   (id_jump_target),
    .pc4              (pc4),
    .sel_target       (sel_target),
    .sel_src          (sel_src),
    .sel_valid        (sel_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_BOOT;
      pend_tgt <= 64'h0;
      pend_src <= SRC_SEQ;
    end else begin
      state    <= state_nxt;
      pend_tgt <= pend_tgt_nxt;
      pend_src <= pend_src_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pend_tgt_nxt = pend_tgt;
    pend_src_nxt = pend_src;
    next_pc      = pc4;
    redirect_src = SRC_SEQ;
    flush_if     = 1'b0;
    flush_id     = 1'b0;
    case (state)
      ST_BOOT: begin
        // Requests are ignored while the reset vector is being fetched.
        next_pc      = RESET_PC;
        redirect_src = SRC_BOOT;
        state_nxt    = ST_RUN;
      end
      ST_RUN: begin
        next_pc      = sel_target;
        redirect_src = sel_src;
        if (sel_valid) begin
          flush_if = 1'b1;
          flush_id = src_flushes_id(sel_src);
          if (!fetch_ready) begin
            pend_tgt_nxt = sel_target;
            pend_src_nxt = sel_src;
            state_nxt    = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // Pending source is always >= SRC_JUMP, so enum order is priority.
        if (sel_valid && (sel_src > pend_src)) begin
          pend_tgt_nxt = sel_target;
          pend_src_nxt = sel_src;
        end
        next_pc      = pend_tgt_nxt;
        redirect_src = pend_src_nxt;
        flush_if     = 1'b1;
        flush_id     = src_flushes_id(pend_src_nxt);
        if (fetch_ready) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

  assign busy = (state == ST_HOLD);

`ifdef CORE_REDIRECT_PERF_EN
  logic redirect_accepted;
  assign redirect_accepted = fetch_ready &&
                             (((state == ST_RUN) && sel_valid) || (state == ST_HOLD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_count <= 32'd0;
      hold_cycles    <= 32'd0;
    end else begin
      if (redirect_accepted) redirect_count <= redirect_count + 32'd1;
      if (state == ST_HOLD)  hold_cycles    <= hold_cycles + 32'd1;
    end
  end
`endif

endmodule
